// File: rtl/root_xbar_arb_pkg.sv
// rtl/root_xbar_arb_pkg.sv - shared sizes and types for the root-power crossbar
// Carries the FHE ALU sizing (LOG_E, E, N, FSIZE) plus the lane word and response tag types.
package root_xbar_arb_pkg;
  localparam int LOG_E      = 2;
  localparam int E          = 4;
  localparam int N          = 64;
  localparam int FSIZE      = 64;
  localparam int RXB_LANES  = LOG_E * (E / 2);
  localparam int RXB_ADDR_W = $clog2(N / (E / 2));
  localparam int TAG_BANK_W = 8;

  typedef logic [RXB_LANES-1:0][FSIZE-1:0] root_lane_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BANK_W-1:0] bank;
    logic                  err;
  } rxb_tag_t;

  function automatic int rxb_src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/root_xbar_arb_if.sv
// rtl/root_xbar_arb_if.sv - consumer request/response bundle of the root-power crossbar
// master = NTT/INTT consumer side, slave = crossbar side.
interface root_xbar_arb_if #(
  parameter int NUM_DST = 4,
  parameter int SRC_W   = 2,
  parameter int ADDR_W  = 5,
  parameter int LANES   = 4,
  parameter int DATA_W  = 64
);
  logic [NUM_DST-1:0]                         req_valid;
  logic [NUM_DST-1:0][SRC_W-1:0]              req_bank;
  logic [NUM_DST-1:0][ADDR_W-1:0]             req_addr;
  logic [NUM_DST-1:0]                         req_grant;
  logic [NUM_DST-1:0]                         rsp_valid;
  logic [NUM_DST-1:0]                         rsp_err;
  logic [NUM_DST-1:0][LANES-1:0][DATA_W-1:0]  rsp_w;
  logic [NUM_DST-1:0][LANES-1:0][DATA_W-1:0]  rsp_wq;

  modport master (
    output req_valid, req_bank, req_addr,
    input  req_grant, rsp_valid, rsp_err, rsp_w, rsp_wq
  );

  modport slave (
    input  req_valid, req_bank, req_addr,
    output req_grant, rsp_valid, rsp_err, rsp_w, rsp_wq
  );
endinterface

// File: rtl/root_xbar_arb_rr_arbiter.sv
// rtl/root_xbar_arb_rr_arbiter.sv - round-robin arbiter, one instance per bank
// Search starts at ptr; ptr moves to winner+1 only when advance is high.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;

  // Walk from the farthest candidate back toward ptr so the nearest requester wins.
  always_comb begin
    grant   = '0;
    nxt_ptr = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        nxt_ptr    = (idx + 1 == NUM_REQ) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= nxt_ptr;
    end
  end
endmodule

// File: rtl/root_xbar_arb.sv
// rtl/root_xbar_arb.sv - root-power RAM crossbar with per-bank round-robin reads and DMA write fan-out
// Optional ROOT_XBAR_STALL_CNT_EN adds per-consumer saturating stall counters.
module root_xbar_arb
  import root_xbar_arb_pkg::*;
#(
  parameter int NUM_DST  = 4,
  parameter int NUM_SRC  = 4,
  parameter int LANES    = RXB_LANES,
  parameter int DATA_W   = FSIZE,
  parameter int ADDR_W   = RXB_ADDR_W,
  parameter int RAM_LAT  = 2,
  parameter int RSP_REGS = 1,
  parameter int SRC_W    = rxb_src_w(NUM_SRC)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  root_xbar_arb_if.slave                          xb,
  output logic [NUM_SRC-1:0]                      bank_rd_en,
  output logic [NUM_SRC-1:0][ADDR_W-1:0]          bank_rd_addr,
  input  logic [NUM_SRC-1:0][LANES-1:0][DATA_W-1:0] bank_rdata_w,
  input  logic [NUM_SRC-1:0][LANES-1:0][DATA_W-1:0] bank_rdata_wq,
  input  logic                                    wr_valid,
  input  logic [NUM_SRC-1:0]                      wr_bank_mask,
  input  logic [ADDR_W-1:0]                       wr_addr,
  input  logic [LANES-1:0]                        wr_lane_en,
  input  logic [LANES-1:0][DATA_W-1:0]            wr_data_w,
  input  logic [LANES-1:0][DATA_W-1:0]            wr_data_wq,
  output logic [NUM_SRC-1:0][LANES-1:0]           bank_wr_en,
  output logic [NUM_SRC-1:0][ADDR_W-1:0]          bank_wr_addr,
  output logic [NUM_SRC-1:0][LANES-1:0][DATA_W-1:0] bank_wdata_w,
  output logic [NUM_SRC-1:0][LANES-1:0][DATA_W-1:0] bank_wdata_wq
`ifdef ROOT_XBAR_STALL_CNT_EN
  ,
  output logic [NUM_DST-1:0][15:0]                stall_cnt
`endif
);
  logic [NUM_DST-1:0]             oor;
  logic [NUM_DST-1:0]             grant_any;
  logic [NUM_DST-1:0]             bank_req  [NUM_SRC];
  logic [NUM_DST-1:0]             arb_grant [NUM_SRC];
  logic [NUM_SRC-1:0][ADDR_W-1:0] win_addr;
  rxb_tag_t                       tag [NUM_DST][RAM_LAT+1];
  logic [NUM_DST-1:0]             tap_valid, tap_err;
  logic [NUM_DST-1:0][LANES-1:0][DATA_W-1:0] tap_w, tap_wq;

  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      oor[d] = int'(xb.req_bank[d]) >= NUM_SRC;
    end
    for (int b = 0; b < NUM_SRC; b++) begin
      bank_req[b] = '0;
      for (int d = 0; d < NUM_DST; d++) begin
        bank_req[b][d] = xb.req_valid[d] && !oor[d] && (int'(xb.req_bank[d]) == b);
      end
    end
  end

  for (genvar b = 0; b < NUM_SRC; b++) begin : g_arb
    rr_arbiter #(.NUM_REQ(NUM_DST)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bank_req[b]),
      .advance ((|arb_grant[b]) & ~rst),
      .grant   (arb_grant[b])
    );
  end

  // Out-of-range requests never touch a bank, so they are accepted unconditionally.
  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      grant_any[d] = xb.req_valid[d] & oor[d];
      for (int b = 0; b < NUM_SRC; b++) grant_any[d] = grant_any[d] | arb_grant[b][d];
    end
    xb.req_grant = rst ? '0 : grant_any;
    for (int b = 0; b < NUM_SRC; b++) begin
      win_addr[b] = '0;
      for (int d = 0; d < NUM_DST; d++) begin
        if (arb_grant[b][d]) win_addr[b] = xb.req_addr[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_rd_en   <= '0;
      bank_rd_addr <= '0;
    end else begin
      for (int b = 0; b < NUM_SRC; b++) begin
        bank_rd_en[b]   <= |arb_grant[b];
        bank_rd_addr[b] <= win_addr[b];
      end
    end
  end

  // Tag stage k is visible k+1 cycles after the grant; stage RAM_LAT lines up with bank read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NUM_DST; d++)
        for (int k = 0; k <= RAM_LAT; k++) tag[d][k] <= '0;
    end else begin
      for (int d = 0; d < NUM_DST; d++) begin
        tag[d][0] <= '{valid: xb.req_grant[d], bank: TAG_BANK_W'(xb.req_bank[d]), err: oor[d]};
        for (int k = 1; k <= RAM_LAT; k++) tag[d][k] <= tag[d][k-1];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      tap_valid[d] = tag[d][RAM_LAT].valid;
      tap_err[d]   = tag[d][RAM_LAT].valid & tag[d][RAM_LAT].err;
      tap_w[d]     = '0;
      tap_wq[d]    = '0;
      if (tag[d][RAM_LAT].valid && !tag[d][RAM_LAT].err) begin
        for (int b = 0; b < NUM_SRC; b++) begin
          if (int'(tag[d][RAM_LAT].bank) == b) begin
            tap_w[d]  = bank_rdata_w[b];
            tap_wq[d] = bank_rdata_wq[b];
          end
        end
      end
    end
  end

  if (RSP_REGS == 0) begin : g_rsp_direct
    assign xb.rsp_valid = tap_valid;
    assign xb.rsp_err   = tap_err;
    assign xb.rsp_w     = tap_w;
    assign xb.rsp_wq    = tap_wq;
  end else begin : g_rsp_pipe
    logic [NUM_DST-1:0]                        pv [RSP_REGS];
    logic [NUM_DST-1:0]                        pe [RSP_REGS];
    logic [NUM_DST-1:0][LANES-1:0][DATA_W-1:0] pw [RSP_REGS];
    logic [NUM_DST-1:0][LANES-1:0][DATA_W-1:0] pq [RSP_REGS];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < RSP_REGS; k++) begin
          pv[k] <= '0;
          pe[k] <= '0;
          pw[k] <= '0;
          pq[k] <= '0;
        end
      end else begin
        pv[0] <= tap_valid;
        pe[0] <= tap_err;
        pw[0] <= tap_w;
        pq[0] <= tap_wq;
        for (int k = 1; k < RSP_REGS; k++) begin
          pv[k] <= pv[k-1];
          pe[k] <= pe[k-1];
          pw[k] <= pw[k-1];
          pq[k] <= pq[k-1];
        end
      end
    end

    assign xb.rsp_valid = pv[RSP_REGS-1];
    assign xb.rsp_err   = pe[RSP_REGS-1];
    assign xb.rsp_w     = pw[RSP_REGS-1];
    assign xb.rsp_wq    = pq[RSP_REGS-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_wr_en    <= '0;
      bank_wr_addr  <= '0;
      bank_wdata_w  <= '0;
      bank_wdata_wq <= '0;
    end else begin
      for (int b = 0; b < NUM_SRC; b++) begin
        bank_wr_en[b]    <= (wr_valid && wr_bank_mask[b]) ? wr_lane_en : '0;
        bank_wr_addr[b]  <= wr_addr;
        bank_wdata_w[b]  <= wr_data_w;
        bank_wdata_wq[b] <= wr_data_wq;
      end
    end
  end

`ifdef ROOT_XBAR_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else begin
      for (int d = 0; d < NUM_DST; d++) begin
        if (xb.req_valid[d] && !xb.req_grant[d] && stall_cnt[d] != 16'hFFFF)
          stall_cnt[d] <= stall_cnt[d] + 16'd1;
      end
    end
  end
`endif
endmodule
